path_transition_tester: RTL and testbench
=========================================

// Module: path_transition_tester
// PURPOSE
// - BIST launch/capture controller for a single sensitized 1-bit combinational path (PI -> PO).
// - Drives the path input, settles it, launches a rising then falling transition, and samples the path output a fixed number of cycles later.
// - Counts slow-to-rise / slow-to-fall failures; init-value mismatches flag stuck-at faults.
// - Sits between the test sequencer and one extracted path netlist; path logic is in the same clock domain.
// PARAMETERS
// - INVERT       0  path parity: expected PO = path_in ^ INVERT
// - SETTLE_CYC   4  cycles path_in is held at init value before launch (>=1)
// - CAPTURE_DLY  1  cycles from launch edge to capture edge (>=1)
// - ITER         8  rise+fall iterations per run (>=1)
// - CNT_W        8  fail counter width
// PORTS
// - clk            in   1      rising-edge clock
// - rst            in   1      synchronous active-high reset
// - start          in   1      run request; sampled only in IDLE
// - abort          in   1      stop run, return to IDLE
// - path_in        out  1      registered drive to path input
// - path_out       in   1      path output, sampled on capture edges
// - busy           out  1      run in progress
// - done           out  1      run complete; level, held until next accepted start
// - pass           out  1      done & no fails & !init_err
// - init_err       out  1      sticky: settled PO != init ^ INVERT
// - rise_fail_cnt  out  CNT_W  slow-to-rise failures, saturating
// - fall_fail_cnt  out  CNT_W  slow-to-fall failures, saturating
// BEHAVIOUR
// - Reset: all outputs 0 (path_in=0, busy=0, done=0, pass=0, init_err=0, counters 0); FSM to IDLE.
// - States: IDLE -> SETTLE -> LAUNCH_WAIT -> (next phase SETTLE | DONE). DONE behaves as IDLE with done=1.
// - Accepted start (IDLE/DONE, abort=0): clears counters, init_err, done, pass; busy=1 next cycle; iteration=0, phase=RISE.
// - Phase RISE: init=0, launch=1. Phase FALL: init=1, launch=0. Each iteration: RISE then FALL.
// - SETTLE: path_in=init for SETTLE_CYC cycles; on last SETTLE edge sample path_out; mismatch vs init^INVERT sets init_err.
// - Launch edge: path_in <= launch. Capture edge = launch edge + CAPTURE_DLY cycles; compare path_out vs launch^INVERT.
// - Mismatch at capture: increment rise or fall counter per phase; saturate at 2^CNT_W-1, no wrap.
// - Phase length exactly SETTLE_CYC+CAPTURE_DLY cycles; no idle cycles between phases/iterations.
// - After FALL of iteration ITER-1: busy=0, done=1, pass computed, path_in<=0; exactly ITER*2*(SETTLE_CYC+CAPTURE_DLY)+1 cycles after start sampled.
// - start while busy: ignored. abort: next cycle busy=0, path_in=0, done=0, pass=0; counters/init_err hold.
// - abort and start same cycle: abort wins, start ignored.
// - Reset mid-run: immediate return to reset state; no partial result retained.
// - Results stable while not busy; no output glitches on path_in (registered).
// TESTING
// - Ideal path (path_out=path_in, comb), defaults, start -> done at cycle 81, pass=1, counters 0, init_err=0.
// - Path model with 2-cycle delay, CAPTURE_DLY=1 -> rise_fail_cnt=8, fall_fail_cnt=8, init_err=0, pass=0.
// - path_out stuck at 0 -> rise_fail_cnt=8, fall_fail_cnt=0, init_err=1, pass=0.
// - ITER=300, CNT_W=8, stuck-at-1 -> fall_fail_cnt=255 (saturated), rise_fail_cnt=0, init_err=1.
// - abort at cycle 20 -> busy=0 and path_in=0 at cycle 21, done stays 0; new start clears counters, full run passes.
// - start pulsed while busy -> no restart, done timing unchanged; start+abort together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/path_transition_tester.sv
// BIST launch/capture controller for one sensitized 1-bit combinational path.
// Settles the path, launches rise/fall transitions, captures after a fixed delay, counts failures.
module path_transition_tester #(
    parameter bit          INVERT      = 1'b0,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned CAPTURE_DLY = 1,
    parameter int unsigned ITER        = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             path_in,
    input  logic             path_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             init_err,
    output logic [CNT_W-1:0] rise_fail_cnt,
    output logic [CNT_W-1:0] fall_fail_cnt
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned CW = $clog2(CAPTURE_DLY + 1);
    localparam int unsigned IW = $clog2(ITER + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StLaunchWait, StDone} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [CW-1:0]    cap_cnt_q, cap_cnt_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic             phase_q, phase_d;  // 0 = rise phase, 1 = fall phase
    logic             path_in_q, path_in_d;
    logic             init_err_q, init_err_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic [CNT_W-1:0] fall_q, fall_d;
    logic             init_val, launch_val;

    assign init_val   = phase_q;
    assign launch_val = ~phase_q;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        iter_d       = iter_q;
        phase_d      = phase_q;
        path_in_d    = path_in_q;
        init_err_d   = init_err_q;
        rise_d       = rise_q;
        fall_d       = fall_q;

        case (state_q)
            StIdle, StDone: begin
                if (abort) begin
                    state_d   = StIdle;
                    path_in_d = 1'b0;
                end else if (start) begin
                    state_d      = StSettle;
                    // The accept cycle adds one extra settle cycle ahead of the first launch.
                    settle_cnt_d = SW'(SETTLE_CYC);
                    iter_d       = '0;
                    phase_d      = 1'b0;
                    path_in_d    = 1'b0;
                    init_err_d   = 1'b0;
                    rise_d       = '0;
                    fall_d       = '0;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d   = StIdle;
                    path_in_d = 1'b0;
                end else if (settle_cnt_q == '0) begin
                    if (path_out != (init_val ^ INVERT)) init_err_d = 1'b1;
                    path_in_d = launch_val;
                    cap_cnt_d = CW'(CAPTURE_DLY - 1);
                    state_d   = StLaunchWait;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            StLaunchWait: begin
                if (abort) begin
                    state_d   = StIdle;
                    path_in_d = 1'b0;
                end else if (cap_cnt_q == '0) begin
                    if (path_out != (launch_val ^ INVERT)) begin
                        if (!phase_q) begin
                            if (rise_q != '1) rise_d = rise_q + 1'b1;
                        end else begin
                            if (fall_q != '1) fall_d = fall_q + 1'b1;
                        end
                    end
                    if (phase_q && (iter_q == IW'(ITER - 1))) begin
                        state_d   = StDone;
                        path_in_d = 1'b0;
                    end else begin
                        if (phase_q) iter_d = iter_q + 1'b1;
                        phase_d      = ~phase_q;
                        // Next phase's init value equals the current launch value.
                        path_in_d    = ~phase_q;
                        settle_cnt_d = SW'(SETTLE_CYC - 1);
                        state_d      = StSettle;
                    end
                end else begin
                    cap_cnt_d = cap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                path_in_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            cap_cnt_q    <= '0;
            iter_q       <= '0;
            phase_q      <= 1'b0;
            path_in_q    <= 1'b0;
            init_err_q   <= 1'b0;
            rise_q       <= '0;
            fall_q       <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            iter_q       <= iter_d;
            phase_q      <= phase_d;
            path_in_q    <= path_in_d;
            init_err_q   <= init_err_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    assign path_in       = path_in_q;
    assign busy          = (state_q == StSettle) || (state_q == StLaunchWait);
    assign done          = (state_q == StDone);
    assign pass          = done && (rise_q == '0) && (fall_q == '0) && !init_err_q;
    assign init_err      = init_err_q;
    assign rise_fail_cnt = rise_q;
    assign fall_fail_cnt = fall_q;

endmodule

// File: tb/tb_path_transition_tester.sv
// Bench for path_transition_tester: cycle-indexed model checked every cycle plus directed
// literal checks on run length, fail counts, abort, reset and saturation.
module tb_path_transition_tester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0;
    logic       path_in, path_out;
    logic       busy, done, pass, init_err;
    logic [7:0] rise_cnt, fall_cnt;

    logic       start_b = 1'b0, abort_b = 1'b0;
    logic       path_in_b, path_out_b;
    logic       busy_b, done_b, pass_b, init_err_b;
    logic [7:0] rise_cnt_b, fall_cnt_b;

    int mode = 0;  // 0 ideal, 1 two-cycle delay, 2 stuck-0, 3 stuck-1
    logic d1 = 1'b0, d2 = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        d1 <= path_in;
        d2 <= d1;
    end

    always_comb begin
        path_out = path_in;
        case (mode)
            1:       path_out = d2;
            2:       path_out = 1'b0;
            3:       path_out = 1'b1;
            default: path_out = path_in;
        endcase
    end

    assign path_out_b = 1'b1;

    path_transition_tester dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .path_in(path_in), .path_out(path_out), .busy(busy), .done(done), .pass(pass),
        .init_err(init_err), .rise_fail_cnt(rise_cnt), .fall_fail_cnt(fall_cnt)
    );

    path_transition_tester #(.ITER(300)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .path_in(path_in_b), .path_out(path_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .init_err(init_err_b), .rise_fail_cnt(rise_cnt_b),
        .fall_fail_cnt(fall_cnt_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit run;
        bit done;
        int k;
        int rise;
        int fall;
        bit ie;
        bit pin;
    } mdl_t;

    // k = number of clock edges since the accepted start; phase p spans s+c cycles,
    // launch lands at offset s within a phase and capture closes the phase.
    function automatic mdl_t mdl_step(input mdl_t m, input int s, input int c, input int it,
                                      input int cw, input bit inv, input bit r, input bit st,
                                      input bit ab, input bit po);
        mdl_t n = m;
        int plen = s + c;
        int sat = (1 << cw) - 1;
        int j, p, o, q;
        bit init_p, launch_q;
        if (r) begin
            n.run = 0; n.done = 0; n.k = 0; n.rise = 0; n.fall = 0; n.ie = 0; n.pin = 0;
        end else if (ab) begin
            n.run = 0; n.done = 0; n.pin = 0;
        end else if (!m.run) begin
            if (st) begin
                n.run = 1; n.done = 0; n.k = 0; n.rise = 0; n.fall = 0; n.ie = 0; n.pin = 0;
            end
        end else begin
            j = m.k;
            n.k = m.k + 1;
            p = j / plen;
            o = j % plen;
            init_p = (p % 2) == 1;
            if (o == s && po != (init_p ^ inv)) n.ie = 1;
            if (j > 0 && o == 0) begin
                q = p - 1;
                launch_q = (q % 2) == 0;
                if (po != (launch_q ^ inv)) begin
                    if (launch_q) n.rise = (m.rise < sat) ? m.rise + 1 : sat;
                    else          n.fall = (m.fall < sat) ? m.fall + 1 : sat;
                end
                if (q == 2 * it - 1) begin
                    n.run = 0; n.done = 1; n.pin = 0;
                    return n;
                end
            end
            n.pin = (o >= s) ? !init_p : init_p;
        end
        return n;
    endfunction

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    initial begin
        forever begin
            @(negedge clk);
            chk("a_busy", busy, ma.run);
            chk("a_done", done, ma.done);
            chk("a_pass", pass, ma.done && ma.rise == 0 && ma.fall == 0 && !ma.ie);
            chk("a_init_err", init_err, ma.ie);
            chk("a_rise", rise_cnt, ma.rise);
            chk("a_fall", fall_cnt, ma.fall);
            chk("a_path_in", path_in, ma.pin);
            chk("b_busy", busy_b, mb.run);
            chk("b_done", done_b, mb.done);
            chk("b_init_err", init_err_b, mb.ie);
            chk("b_rise", rise_cnt_b, mb.rise);
            chk("b_fall", fall_cnt_b, mb.fall);
            chk("b_path_in", path_in_b, mb.pin);
            ma = mdl_step(ma, 4, 1, 8, 8, 1'b0, rst, start, abort, path_out);
            mb = mdl_step(mb, 4, 1, 300, 8, 1'b0, rst, start_b, abort_b, path_out_b);
        end
    end

    task automatic run_a(input int poke, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
            start = (cyc == poke);
        end
        start = 1'b0;
    endtask

    int cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_path_in", path_in, 0);
        chk("reset_cnts", {rise_cnt, fall_cnt}, 0);

        // Ideal path with a start pulse mid-run that must be ignored.
        mode = 0;
        run_a(30, cyc);
        chk("ideal_cycles", cyc, 81);
        chk("ideal_pass", pass, 1);
        chk("ideal_cnts", {rise_cnt, fall_cnt, 7'd0, init_err}, 0);

        // start + abort together: stays idle and clears the done level.
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_done", done, 0);
        repeat (3) @(posedge clk);
        #1 chk("start_abort_idle", busy, 0);

        mode = 1;
        run_a(-1, cyc);
        chk("delay_rise", rise_cnt, 8);
        chk("delay_fall", fall_cnt, 8);
        chk("delay_init_err", init_err, 0);
        chk("delay_pass", pass, 0);

        mode = 2;
        run_a(-1, cyc);
        chk("stuck0_rise", rise_cnt, 8);
        chk("stuck0_fall", fall_cnt, 0);
        chk("stuck0_init_err", init_err, 1);
        chk("stuck0_pass", pass, 0);

        // Abort at cycle 20 of a stuck-0 run.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_path_in", path_in, 0);
        chk("abort_done", done, 0);
        chk("abort_rise_hold", rise_cnt, 2);
        chk("abort_init_err_hold", init_err, 1);
        repeat (4) @(posedge clk);
        #1 chk("abort_done_stays", done, 0);
        mode = 0;
        run_a(-1, cyc);
        chk("after_abort_cycles", cyc, 81);
        chk("after_abort_pass", pass, 1);

        // Reset mid-run.
        mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_state", {rise_cnt, fall_cnt, 5'd0, init_err, done, path_in}, 0);

        // Saturation on the 300-iteration instance with a stuck-at-1 output.
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("sat_cycles", cyc, 3001);
        chk("sat_fall", fall_cnt_b, 255);
        chk("sat_rise", rise_cnt_b, 0);
        chk("sat_init_err", init_err_b, 1);
        chk("sat_pass", pass_b, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
